mlp_pe_scheduler: RTL and testbench

Time-multiplexing scheduler for a shared bank of `N_PE` multiply-accumulate processing elements in the MLP inference datapath. For each test vector it fetches the sample, then evaluates the hidden layer and the output layer in groups of up to `N_PE` neurons. It drives operand indices, accumulator control and write-back, and tallies correct classifications. It sits between the top-level run control (`start`/`done`) and the PE bank, weight ROMs and layer buffers.

---
 rtl/mlp_pkg.sv | 21 ++
 rtl/mlp_pe_scheduler_if.sv | 31 +++
 rtl/mlp_mask_gen.sv | 15 +
 rtl/mlp_pe_scheduler.sv | 137 +++++++++++++
 tb/tb_mlp_pe_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// mlp_pkg: shared state encoding, default MLP layer sizes and the constants derived from them.
package mlp_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CLEAR, S_MAC, S_WB, S_CHECK} state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int N_INPUTS_D   = 62;
    localparam int N_HIDDEN_D   = 30;
    localparam int N_OUTPUT_D   = 10;
    localparam int N_PE_D       = 10;
    localparam int N_TESTS_D    = 750;
    localparam int HID_FANIN_D  = N_INPUTS_D;
    localparam int OUT_FANIN_D  = N_HIDDEN_D;
    localparam int HID_GROUPS_D = (N_HIDDEN_D + N_PE_D - 1) / N_PE_D;
    localparam int OUT_GROUPS_D = (N_OUTPUT_D + N_PE_D - 1) / N_PE_D;
    localparam int IDX_W_D      = $clog2(HID_FANIN_D > OUT_FANIN_D ? HID_FANIN_D : OUT_FANIN_D);
    localparam int GRP_W_D      = $clog2(HID_GROUPS_D > OUT_GROUPS_D ? HID_GROUPS_D : OUT_GROUPS_D);
    localparam int TST_W_D      = $clog2(N_TESTS_D + 1);
endpackage

// File: rtl/mlp_pe_scheduler_if.sv
// mlp_pe_scheduler_if: scheduler <-> sample loader / PE bank / layer buffer signalling.
interface mlp_pe_scheduler_if
    import mlp_pkg::*;
#(
    parameter int N_PE  = N_PE_D,
    parameter int IDX_W = IDX_W_D,
    parameter int GRP_W = GRP_W_D,
    parameter int TST_W = TST_W_D
);
    logic             sample_req;
    logic             sample_ack;
    logic [TST_W-1:0] test_idx;
    logic             w_valid;
    logic             layer;
    logic [GRP_W-1:0] group;
    logic [IDX_W-1:0] in_idx;
    logic             pe_clear;
    logic             pe_acc_en;
    logic [N_PE-1:0]  pe_mask;
    logic             wb_en;
    logic             pred_match;

    modport master (
        output sample_req, test_idx, layer, group, in_idx, pe_clear, pe_acc_en, pe_mask, wb_en,
        input  sample_ack, w_valid, pred_match
    );
    modport slave (
        input  sample_req, test_idx, layer, group, in_idx, pe_clear, pe_acc_en, pe_mask, wb_en,
        output sample_ack, w_valid, pred_match
    );
endinterface

// File: rtl/mlp_mask_gen.sv
// mlp_mask_gen: flags the PEs of a group that map onto a real neuron of the current layer.
module mlp_mask_gen #(
    parameter int N_PE  = 10,
    parameter int GRP_W = 2
) (
    input  logic [GRP_W-1:0] group,
    input  logic [31:0]      neurons,
    output logic [N_PE-1:0]  mask
);
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_PE; i++)
            mask[i] = (32'(group) * 32'(N_PE) + 32'(i)) < neurons;
    end
endmodule

// File: rtl/mlp_pe_scheduler.sv
// mlp_pe_scheduler: time-multiplexes a shared MAC PE bank over the hidden and output layers per test vector.
// Define MLP_PE_SCHED_PERF_EN to add the stall_cnt / cycle_cnt performance counters.
module mlp_pe_scheduler
    import mlp_pkg::*;
#(
    parameter int N_INPUTS = N_INPUTS_D,
    parameter int N_HIDDEN = N_HIDDEN_D,
    parameter int N_OUTPUT = N_OUTPUT_D,
    parameter int N_PE     = N_PE_D,
    parameter int N_TESTS  = N_TESTS_D,
    parameter int IDX_W    = IDX_W_D,
    parameter int GRP_W    = GRP_W_D,
    parameter int TST_W    = TST_W_D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    mlp_pe_scheduler_if.master       bus,
    output logic [TST_W-1:0]         correct_cnt,
    output logic                     busy,
    output logic                     done
`ifdef MLP_PE_SCHED_PERF_EN
    ,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              cycle_cnt
`endif
);
    localparam int HID_GROUPS = ceil_div(N_HIDDEN, N_PE);
    localparam int OUT_GROUPS = ceil_div(N_OUTPUT, N_PE);

    state_t           state, state_n;
    logic [TST_W-1:0] test_q, test_n, corr_q, corr_n;
    logic [GRP_W-1:0] group_q, group_n, last_grp;
    logic [IDX_W-1:0] idx_q, idx_n, last_idx;
    logic             layer_q, layer_n, done_q, done_n;
    logic [N_PE-1:0]  mask;

    assign last_idx = layer_q ? IDX_W'(N_HIDDEN - 1) : IDX_W'(N_INPUTS - 1);
    assign last_grp = layer_q ? GRP_W'(OUT_GROUPS - 1) : GRP_W'(HID_GROUPS - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            test_q  <= '0;
            corr_q  <= '0;
            group_q <= '0;
            idx_q   <= '0;
            layer_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            test_q  <= test_n;
            corr_q  <= corr_n;
            group_q <= group_n;
            idx_q   <= idx_n;
            layer_q <= layer_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        test_n  = test_q;
        corr_n  = corr_q;
        group_n = group_q;
        idx_n   = idx_q;
        layer_n = layer_q;
        done_n  = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_n = S_FETCH;
                test_n  = '0;
                corr_n  = '0;
            end
            S_FETCH: if (bus.sample_ack) begin
                state_n = S_CLEAR;
                layer_n = 1'b0;
                group_n = '0;
            end
            S_CLEAR: begin
                state_n = S_MAC;
                idx_n   = '0;
            end
            // the index wraps to 0 on the last operand so it never shows fan-in
            S_MAC: if (bus.w_valid) begin
                idx_n   = (idx_q == last_idx) ? '0 : idx_q + 1'b1;
                state_n = (idx_q == last_idx) ? S_WB : S_MAC;
            end
            S_WB: begin
                state_n = (group_q != last_grp || !layer_q) ? S_CLEAR : S_CHECK;
                group_n = (group_q != last_grp) ? group_q + 1'b1 : '0;
                layer_n = layer_q | (group_q == last_grp);
            end
            S_CHECK: begin
                corr_n  = corr_q + TST_W'(bus.pred_match);
                done_n  = (test_q == TST_W'(N_TESTS - 1));
                state_n = done_n ? S_IDLE : S_FETCH;
                test_n  = done_n ? test_q : test_q + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    mlp_mask_gen #(.N_PE(N_PE), .GRP_W(GRP_W)) u_mask (
        .group   (group_q),
        .neurons (layer_q ? 32'(N_OUTPUT) : 32'(N_HIDDEN)),
        .mask    (mask)
    );

    assign busy           = state != S_IDLE;
    assign done           = done_q;
    assign correct_cnt    = corr_q;
    assign bus.sample_req = state == S_FETCH;
    assign bus.test_idx   = test_q;
    assign bus.layer      = layer_q;
    assign bus.group      = group_q;
    assign bus.in_idx     = idx_q;
    assign bus.pe_clear   = state == S_CLEAR;
    assign bus.pe_acc_en  = (state == S_MAC) && bus.w_valid;
    assign bus.pe_mask    = busy ? mask : '0;
    assign bus.wb_en      = state == S_WB;

`ifdef MLP_PE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            cycle_cnt <= '0;
        end else if (state == S_IDLE) begin
            stall_cnt <= start ? '0 : stall_cnt;
            cycle_cnt <= start ? '0 : cycle_cnt;
        end else begin
            cycle_cnt <= cycle_cnt + 1;
            stall_cnt <= stall_cnt + 32'((state == S_MAC && !bus.w_valid) || (state == S_FETCH && !bus.sample_ack));
        end
    end
`endif
endmodule

// File: tb/tb_mlp_pe_scheduler.sv
// tb_mlp_pe_scheduler: directed checks of the PE scheduler on three parameterisations.
module tb_mlp_pe_scheduler;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic start0 = 0, start1 = 0, start2 = 0;
    logic busy0, busy1, busy2, done0, done1, done2;
    logic [9:0] corr0, corr1, corr2;
    logic seen0 = 0, seen1 = 0, seen2 = 0;
    logic [31:0] stall0, ccnt0, stall1, ccnt1, stall2, ccnt2;
    logic [9:0] masks1[$];

    mlp_pe_scheduler_if bus0 ();
    mlp_pe_scheduler_if bus1 ();
    mlp_pe_scheduler_if bus2 ();

    mlp_pe_scheduler #(.N_TESTS(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .bus(bus0),
        .correct_cnt(corr0), .busy(busy0), .done(done0)
`ifdef MLP_PE_SCHED_PERF_EN
        , .stall_cnt(stall0), .cycle_cnt(ccnt0)
`endif
    );
    mlp_pe_scheduler #(.N_INPUTS(4), .N_HIDDEN(25), .N_TESTS(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .bus(bus1),
        .correct_cnt(corr1), .busy(busy1), .done(done1)
`ifdef MLP_PE_SCHED_PERF_EN
        , .stall_cnt(stall1), .cycle_cnt(ccnt1)
`endif
    );
    mlp_pe_scheduler #(.N_INPUTS(3), .N_HIDDEN(3), .N_OUTPUT(2), .N_TESTS(750)) u2 (
        .clk(clk), .rst(rst), .start(start2), .bus(bus2),
        .correct_cnt(corr2), .busy(busy2), .done(done2)
`ifdef MLP_PE_SCHED_PERF_EN
        , .stall_cnt(stall2), .cycle_cnt(ccnt2)
`endif
    );

    // sample loaders answer one cycle after the request appears
    initial forever begin
        @(negedge clk);
        bus0.sample_ack = bus0.sample_req & seen0;
        seen0 = bus0.sample_req;
        bus1.sample_ack = bus1.sample_req & seen1;
        seen1 = bus1.sample_req;
        bus2.sample_ack = bus2.sample_req & seen2;
        seen2 = bus2.sample_req;
        bus2.pred_match = ~bus2.test_idx[0];
    end

    always @(negedge clk) if (bus1.wb_en) masks1.push_back(bus1.pe_mask);

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_clear0();
        int n = 0;
        while (!bus0.pe_clear && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("clear_seen", bus0.pe_clear, 1);
    endtask

    task automatic run_group0(input int fanin, input bit rnd, output int stl);
        int acc = 0, en = 0, bad = 0, it = 0;
        logic v;
        stl = 0;
        wait_clear0();
        bus0.w_valid = 1'($urandom_range(0, 1));
        #1 if (bus0.pe_acc_en) en++;
        @(negedge clk);
        while (acc < fanin) begin
            v = (rnd && it < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus0.w_valid = v;
            #1;
            if (bus0.pe_acc_en) en++;
            if (int'(bus0.in_idx) != acc) bad++;
            if (v) acc++;
            else stl++;
            it++;
            @(negedge clk);
        end
        bus0.w_valid = 0;
        check("wb_after_mac", bus0.wb_en, 1);
        check("acc_en_count", en, fanin);
        check("in_idx_track_errs", bad, 0);
        check("mask_default", bus0.pe_mask, 10'h3FF);
    endtask

    task automatic run_test0(input bit rnd, input bit pulse, output int cycles, output int stl_total);
        int s, c0, n = 0;
        stl_total = 0;
        wait_clear0();
        c0 = cyc;
        for (int g = 0; g < 4; g++) begin
            run_group0(g < 3 ? 62 : 30, rnd, s);
            stl_total += s;
            if (pulse && g == 0) begin
                start0 = 1;
                @(negedge clk);
                start0 = 0;
            end
        end
        while (!done0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done0, 1);
        cycles = cyc - c0;
    endtask

    initial begin
        int cycles, stl, n;
        logic [9:0] exp_mask [4] = '{10'h3FF, 10'h3FF, 10'h01F, 10'h3FF};
        bus0.w_valid = 0; bus0.pred_match = 0;
        bus1.w_valid = 1; bus1.pred_match = 0;
        bus2.w_valid = 1;
        #1 rst = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_test_idx", bus0.test_idx, 0);
        check("rst_correct", corr0, 0);
        check("rst_mask", bus0.pe_mask, 0);
        check("rst_in_idx", bus0.in_idx, 0);
        check("rst_outs", {done0, bus0.sample_req, bus0.pe_clear, bus0.wb_en, bus0.layer, bus0.group}, 0);
        rst = 1;
        @(negedge clk);

        // stall-free single test with a stray start pulse mid-run
        bus0.pred_match = 1;
        start0 = 1;
        @(negedge clk);
        start0 = 0;
        check("fetch_next_cycle", bus0.sample_req, 1);
        run_test0(0, 1, cycles, stl);
        check("cycles_clear_to_done", cycles, 225);
        check("done_test_idx", bus0.test_idx, 0);
        check("done_correct", corr0, 1);
`ifdef MLP_PE_SCHED_PERF_EN
        check("perf_stall_clean", stall0, 1);
        check("perf_cycle_clean", ccnt0, 227);
`endif
        @(negedge clk);
        check("done_one_cycle", done0, 0);
        check("busy_dropped", busy0, 0);
        check("idle_hold_correct", corr0, 1);

        // reset in the middle of the first hidden group
        start0 = 1;
        @(negedge clk);
        start0 = 0;
        wait_clear0();
        @(negedge clk);
        bus0.w_valid = 1;
        repeat (17) @(negedge clk);
        check("mid_mac_in_idx", bus0.in_idx, 17);
        bus0.w_valid = 0;
        rst = 0;
        #1;
        check("async_rst_busy", busy0, 0);
        check("async_rst_correct", corr0, 0);
        check("async_rst_outs", {done0, bus0.sample_req, bus0.pe_clear, bus0.wb_en, bus0.layer, bus0.group, bus0.in_idx, bus0.pe_mask, bus0.test_idx}, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("post_rst_idle", busy0, 0);

        // random w_valid stalls
        start0 = 1;
        @(negedge clk);
        start0 = 0;
        check("restart_fetch", bus0.sample_req, 1);
        run_test0(1, 0, cycles, stl);
        check("cycles_with_stalls", cycles, 225 + stl);
        check("rnd_correct", corr0, 1);
        check("rnd_test_idx", bus0.test_idx, 0);
`ifdef MLP_PE_SCHED_PERF_EN
        check("perf_stall_rnd", stall0, stl + 1);
        check("perf_cycle_rnd", ccnt0, 227 + stl);
`endif

        // partial last hidden group
        start1 = 1;
        @(negedge clk);
        start1 = 0;
        n = 0;
        while (!done1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mask_run_done", done1, 1);
        check("mask_wb_count", masks1.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("mask_group%0d", i), masks1.size() > i ? masks1[i] : 10'h0, exp_mask[i]);
        check("mask_run_correct", corr1, 0);

        // full 750-test run, even tests predicted correctly
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        n = 0;
        while (!done2 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("full_done", done2, 1);
        check("full_correct", corr2, 375);
        check("full_test_idx", bus2.test_idx, 749);
        @(negedge clk);
        check("full_busy_after", busy2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
